pkt_gen: RTL and testbench

PKT_GEN -- requirements
Module: pkt_gen

---
 rtl/pkt_gen.sv | 177 +++++++++++++++++
 tb/tb_pkt_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_gen.sv
// Packet generator: emits a header beat followed by ceil(len/(DW/8)) payload beats,
// then an optional idle gap. Payload is LFSR, incrementing, constant 0xA5 or zero.
//
// state | meaning
// IDLE  | ready for a request
// HDR   | header beat on the output
// DATA  | payload beats on the output
// GAP   | inter-packet idle cycles
module pkt_gen #(
    parameter int DW    = 32,
    parameter int LEN_W = 10,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       i_da,
    input  logic [2:0]       i_prior,
    input  logic [LEN_W-1:0] i_len,
    input  logic [1:0]       i_mode,
    input  logic [GAP_W-1:0] i_gap,
    input  logic             i_gen_vld,
    output logic             o_gen_ready,
    input  logic             i_out_ready,
    output logic             o_sop,
    output logic             o_vld,
    output logic [DW-1:0]    o_data,
    output logic             o_eop,
    output logic [15:0]      o_pkt_cnt
);

    localparam int BPB = DW / 8;
    localparam int WPD = DW / 32;
    localparam int LW1 = LEN_W + 1;
    localparam int SW  = LEN_W + $clog2(BPB) + 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       da_q;
    logic [2:0]       prior_q;
    logic [LEN_W-1:0] len_q;
    logic [1:0]       mode_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [LEN_W:0]   beat_cnt_q;
    logic [31:0]      lfsr_q;
    logic [7:0]       byte_q;
    logic [15:0]      pkt_cnt_q;

    logic [SW-1:0]    len_sum;
    logic [LEN_W:0]   n_beats;
    logic [31:0]      lfsr_nxt;
    logic [31:0]      seed;
    logic [DW-1:0]    hdr_word;
    logic [DW-1:0]    inc_word;
    logic [DW-1:0]    payload;
    logic             req_acc;
    logic             beat_acc;

    assign len_sum  = SW'(i_len) + SW'(BPB - 1);
    assign n_beats  = LW1'(len_sum / SW'(BPB));
    assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    assign seed     = {24'h0, i_da, i_prior, i_len[0]} | 32'h1;
    assign hdr_word = DW'({len_q, prior_q, da_q});
    assign req_acc  = i_gen_vld && o_gen_ready;
    assign beat_acc = o_vld && i_out_ready;
    assign o_pkt_cnt = pkt_cnt_q;

    // Incrementing mode: byte_q holds the payload byte index of the current beat's byte 0.
    always_comb begin
        inc_word = '0;
        for (int j = 0; j < BPB; j++) begin
            inc_word[8*j +: 8] = byte_q + 8'(j);
        end
    end

    always_comb begin
        payload = '0;
        case (mode_q)
            2'd0:    payload = {WPD{lfsr_nxt}};
            2'd1:    payload = inc_word;
            2'd2:    payload = {BPB{8'hA5}};
            default: payload = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_gen_ready = 1'b0;
        o_vld       = 1'b0;
        o_sop       = 1'b0;
        o_eop       = 1'b0;
        o_data      = '0;
        case (state_q)
            IDLE: begin
                o_gen_ready = 1'b1;
                if (i_gen_vld) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                o_vld  = 1'b1;
                o_sop  = 1'b1;
                o_eop  = (beat_cnt_q == '0);
                o_data = hdr_word;
                if (i_out_ready) begin
                    if (beat_cnt_q != '0) begin
                        state_d = DATA;
                    end else if (gap_cnt_q != '0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                o_vld  = 1'b1;
                o_eop  = (beat_cnt_q == LW1'(1));
                o_data = payload;
                if (i_out_ready && o_eop) begin
                    state_d = (gap_cnt_q != '0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            da_q       <= '0;
            prior_q    <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            gap_cnt_q  <= '0;
            beat_cnt_q <= '0;
            lfsr_q     <= '0;
            byte_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (req_acc) begin
                da_q       <= i_da;
                prior_q    <= i_prior;
                len_q      <= i_len;
                mode_q     <= i_mode;
                gap_cnt_q  <= i_gap;
                beat_cnt_q <= n_beats;
                lfsr_q     <= seed;
                byte_q     <= '0;
            end
            if (state_q == DATA && beat_acc) begin
                beat_cnt_q <= beat_cnt_q - LW1'(1);
                lfsr_q     <= lfsr_nxt;
                byte_q     <= byte_q + 8'(BPB);
            end
            if (state_q == GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
            if (beat_acc && o_eop) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_gen.sv
// Directed bench for pkt_gen: a table of packet requests with hand-computed beats,
// plus backpressure and mid-packet reset sequences. A 64-bit instance covers wide words.
module tb_pkt_gen;

    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_da = '0;
    logic [2:0]  i_prior = '0;
    logic [9:0]  i_len = '0;
    logic [1:0]  i_mode = '0;
    logic [7:0]  i_gap = '0;
    logic        i_gen_vld = 1'b0;
    logic        i_out_ready = 1'b1;

    logic        rdy32, sop32, vld32, eop32;
    logic [31:0] d32;
    logic [15:0] cnt32;
    logic        rdy64, sop64, vld64, eop64;
    logic [63:0] d64;
    logic [15:0] cnt64;

    bit          sel64 = 1'b0;
    logic        cur_rdy, cur_sop, cur_vld, cur_eop;
    logic [63:0] cur_data;
    logic [15:0] cur_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [3:0]  da;
        logic [2:0]  prior;
        logic [9:0]  len;
        logic [1:0]  mode;
        logic [7:0]  gap;
        bit          wide;
        logic [31:0] hdr;
        int          nbeats;
        logic [63:0] first;
        logic [63:0] last;
    } vec_t;

    vec_t vecs [9];
    vec_t bp_vec;

    always #5 clk = ~clk;

    pkt_gen #(.DW(32), .LEN_W(10), .GAP_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .i_da(i_da), .i_prior(i_prior), .i_len(i_len),
        .i_mode(i_mode), .i_gap(i_gap), .i_gen_vld(i_gen_vld), .o_gen_ready(rdy32),
        .i_out_ready(i_out_ready), .o_sop(sop32), .o_vld(vld32), .o_data(d32),
        .o_eop(eop32), .o_pkt_cnt(cnt32)
    );

    pkt_gen #(.DW(64), .LEN_W(10), .GAP_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .i_da(i_da), .i_prior(i_prior), .i_len(i_len),
        .i_mode(i_mode), .i_gap(i_gap), .i_gen_vld(i_gen_vld), .o_gen_ready(rdy64),
        .i_out_ready(i_out_ready), .o_sop(sop64), .o_vld(vld64), .o_data(d64),
        .o_eop(eop64), .o_pkt_cnt(cnt64)
    );

    always_comb begin
        cur_rdy  = sel64 ? rdy64 : rdy32;
        cur_sop  = sel64 ? sop64 : sop32;
        cur_vld  = sel64 ? vld64 : vld32;
        cur_eop  = sel64 ? eop64 : eop32;
        cur_data = sel64 ? d64 : {32'h0, d32};
        cur_cnt  = sel64 ? cnt64 : cnt32;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_gen_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic send_req(input vec_t v, output bit ok);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!cur_rdy && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        ok = cur_rdy;
        if (!ok) begin
            chk("req_timeout", 64'(cur_rdy), 64'(1));
            return;
        end
        i_da = v.da; i_prior = v.prior; i_len = v.len; i_mode = v.mode; i_gap = v.gap;
        i_gen_vld = 1'b1;
        @(negedge clk);
        i_gen_vld = 1'b0;
    endtask

    task automatic run_pkt(input vec_t v, input bit bp);
        int nb, cyc, gapc;
        bit ok, done, prev_stall;
        logic [63:0] prev_d;
        logic [1:0] prev_f;
        logic [3:0] pat;
        pat = 4'b1001;
        send_req(v, ok);
        if (!ok) return;
        nb = 0; cyc = 0; done = 0; prev_stall = 0; prev_d = '0; prev_f = '0;
        while (!done && cyc < BUDGET) begin
            i_out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                chk("hold_data", cur_data, prev_d);
                chk("hold_flags", 64'({cur_sop, cur_eop}), 64'(prev_f));
            end
            if (cur_vld && i_out_ready) begin
                if (nb == 0) begin
                    chk("hdr_data", cur_data, 64'(v.hdr));
                    chk("hdr_sop", 64'(cur_sop), 64'(1));
                end else begin
                    chk("pay_sop", 64'(cur_sop), 64'(0));
                    if (nb == 1) chk("pay_first", cur_data, v.first);
                    if (nb == v.nbeats) chk("pay_last", cur_data, v.last);
                end
                if (cur_eop) begin
                    done = 1;
                    chk("eop_pos", 64'(nb), 64'(v.nbeats));
                end
                nb++;
            end
            prev_stall = cur_vld && !i_out_ready;
            prev_d = cur_data;
            prev_f = {cur_sop, cur_eop};
            @(negedge clk);
            cyc++;
        end
        i_out_ready = 1'b1;
        if (!done) begin
            chk("eop_timeout", 64'(done), 64'(1));
            return;
        end
        exp_cnt++;
        chk("pkt_cnt", 64'(cur_cnt), 64'(exp_cnt & 16'hFFFF));
        gapc = 0;
        while (!cur_rdy && gapc < BUDGET) begin
            chk("gap_idle", {cur_vld, cur_sop, cur_eop, cur_data[60:0]}, 64'(0));
            @(negedge clk);
            gapc++;
        end
        chk("gap_len", 64'(gapc), 64'(v.gap));
    endtask

    initial begin
        int nb, cyc;
        bit ok, hit;

        vecs[0] = '{4'd3, 3'd5, 10'd8,    2'd1, 8'd0, 1'b0, 32'h0000_0453, 2,
                    64'h0302_0100, 64'h0706_0504};
        vecs[1] = '{4'hA, 3'd2, 10'd9,    2'd2, 8'd1, 1'b0, 32'h0000_04AA, 3,
                    64'hA5A5_A5A5, 64'hA5A5_A5A5};
        vecs[2] = '{4'd1, 3'd7, 10'd5,    2'd3, 8'd0, 1'b0, 32'h0000_02F1, 2,
                    64'h0, 64'h0};
        vecs[3] = '{4'hF, 3'd0, 10'd0,    2'd1, 8'd2, 1'b0, 32'h0000_000F, 0,
                    64'h0, 64'h0};
        vecs[4] = '{4'd2, 3'd1, 10'd1023, 2'd1, 8'd0, 1'b0, 32'h0001_FF92, 256,
                    64'h0302_0100, 64'hFFFE_FDFC};
        vecs[5] = '{4'd3, 3'd5, 10'd4,    2'd0, 8'd0, 1'b0, 32'h0000_0253, 1,
                    64'h8020_001E, 64'h8020_001E};
        vecs[6] = '{4'd0, 3'd0, 10'd8,    2'd0, 8'd0, 1'b0, 32'h0000_0400, 2,
                    64'h8020_0003, 64'hC030_0002};
        vecs[7] = vecs[6];
        vecs[8] = '{4'd3, 3'd5, 10'd12,   2'd1, 8'd0, 1'b1, 32'h0000_0653, 2,
                    64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908};
        bp_vec  = '{4'd2, 3'd1, 10'd9,    2'd2, 8'd1, 1'b0, 32'h0000_0492, 3,
                    64'hA5A5_A5A5, 64'hA5A5_A5A5};

        @(negedge clk);
        @(negedge clk);
        chk("rst_outs", {cur_vld, cur_sop, cur_eop, cur_data[60:0]}, 64'(0));
        chk("rst_cnt", 64'(cur_cnt), 64'(0));
        chk("rst_ready", 64'(cur_rdy), 64'(1));
        rst_n = 1'b1;

        run_pkt(bp_vec, 1'b1);

        // Reset asserted while the second payload beat is on the output.
        send_req('{4'd1, 3'd1, 10'd16, 2'd1, 8'd0, 1'b0, 32'h0, 4, 64'h0, 64'h0}, ok);
        nb = 0; cyc = 0; hit = 0;
        while (ok && !hit && cyc < BUDGET) begin
            if (cur_vld && nb == 2) begin
                hit = 1;
            end else begin
                if (cur_vld && i_out_ready) nb++;
                @(negedge clk);
                cyc++;
            end
        end
        chk("midrst_reached", 64'(hit), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {cur_vld, cur_sop, cur_eop, cur_data[60:0]}, 64'(0));
        chk("midrst_cnt", 64'(cur_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        chk("postrst_ready", 64'(cur_rdy), 64'(1));
        chk("postrst_idle", {cur_vld, cur_cnt}, 64'(0));
        run_pkt(vecs[0], 1'b0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wide) begin
                do_reset();
                sel64 = 1'b1;
            end
            run_pkt(vecs[i], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
